issue_stage: RTL and testbench



---
 rtl/issue_pkg.sv | 22 ++
 rtl/issue_stage_regfile.sv | 42 ++++
 rtl/issue_stage.sv | 148 ++++++++++++++
 tb/tb_issue_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and constants for the issue stage.
// Optional same-cycle writeback forwarding: ISSUE_WB_BYPASS_EN.
package issue_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int CTRL_W = 40;
    localparam int RA_W   = 5;

    typedef struct packed {
        logic [7:0] fn;
        logic [7:0] alu_fn;
        logic [7:0] mem_op;
        logic [7:0] mulDiv_op;
        logic [7:0] flags;
    } ctrl_t;

    function automatic logic is_x0(input logic [RA_W-1:0] a);
        return a == '0;
    endfunction

endpackage

// File: rtl/issue_stage_regfile.sv
// 32x32 register file: two async read ports, one sync write port.
// With ISSUE_WB_BYPASS_EN, a same-cycle write forwards into the reads.
module issue_stage_regfile
    import issue_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [RA_W-1:0] raddr1_i,
    input  logic [RA_W-1:0] raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  logic [RA_W-1:0] waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [NREGS-1:0][XLEN-1:0] mem_q;
    logic                       wr_ok;

    assign wr_ok = we_i && !is_x0(waddr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else if (wr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = is_x0(raddr1_i) ? '0 : mem_q[raddr1_i];
        rdata2_o = is_x0(raddr2_i) ? '0 : mem_q[raddr2_i];
`ifdef ISSUE_WB_BYPASS_EN
        if (wr_ok && waddr_i == raddr1_i) rdata1_o = wdata_i;
        if (wr_ok && waddr_i == raddr2_i) rdata2_o = wdata_i;
`else
        rdata1_o = rdata1_o;
        rdata2_o = rdata2_o;
`endif
    end

endmodule

// File: rtl/issue_stage.sv
// Issue stage: operand read, busy scoreboard, registered slot to execute.
// Optional same-cycle writeback forwarding: ISSUE_WB_BYPASS_EN.
module issue_stage
    import issue_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RA_W-1:0]   rs1,
    input  logic [RA_W-1:0]   rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic [RA_W-1:0]   rd,
    input  logic              we,
    input  logic              use_imm,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   pc,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              flush,
    input  logic              we6,
    input  logic [RA_W-1:0]   rd6,
    input  logic [XLEN-1:0]   wb_data6,
    output logic              valid4,
    output logic [XLEN-1:0]   op_a,
    output logic [XLEN-1:0]   op_b,
    output logic [RA_W-1:0]   rd4,
    output logic              we4,
    output logic [XLEN-1:0]   pc4,
    output logic [CTRL_W-1:0] ctrl4,
    output logic [XLEN-1:0]   rs2_data4
);

    logic [NREGS-1:0] busy_q, busy_d, busy_eff;
    logic             hazard, issue, sb_set, sb_clr;
    logic [XLEN-1:0]  rf_a, rf_b;

    logic             valid_q, valid_d;
    logic             we4_q, we4_d;
    logic [RA_W-1:0]  rd4_q, rd4_d;
    logic [XLEN-1:0]  op_a_q, op_a_d;
    logic [XLEN-1:0]  op_b_q, op_b_d;
    logic [XLEN-1:0]  pc4_q, pc4_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    ctrl_t            ctrl_q, ctrl_d;

    issue_stage_regfile u_rf (
        .clk_i    (clk),
        .rst_i    (nrst),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rf_a),
        .rdata2_o (rf_b),
        .we_i     (we6),
        .waddr_i  (rd6),
        .wdata_i  (wb_data6)
    );

    assign sb_clr = we6 && !is_x0(rd6);

    // Busy view used for hazard detection; bypass hides the retiring reg.
    always_comb begin
        busy_eff    = busy_q;
        busy_eff[0] = 1'b0;
`ifdef ISSUE_WB_BYPASS_EN
        if (sb_clr) busy_eff[rd6] = 1'b0;
`else
        busy_eff = busy_eff;
`endif
    end

    assign hazard = (use_rs1 && busy_eff[rs1])
                  || (use_rs2 && busy_eff[rs2])
                  || (we && busy_eff[rd]);

    assign in_ready = !hazard && !nrst;
    assign issue    = in_valid && in_ready && !flush;
    assign sb_set   = issue && we && !is_x0(rd);

    // Set is applied after clear so a new writer keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (sb_clr) busy_d[rd6] = 1'b0;
        if (sb_set) busy_d[rd]  = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        valid_d = 1'b0;
        we4_d   = 1'b0;
        rd4_d   = '0;
        ctrl_d  = '0;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        pc4_d   = pc4_q;
        rs2_d   = rs2_q;
        if (issue) begin
            valid_d = 1'b1;
            we4_d   = we;
            rd4_d   = rd;
            ctrl_d  = ctrl_t'(ctrl);
            op_a_d  = rf_a;
            op_b_d  = use_imm ? imm : rf_b;
            pc4_d   = pc;
            rs2_d   = rf_b;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            busy_q  <= '0;
            valid_q <= 1'b0;
            we4_q   <= 1'b0;
            rd4_q   <= '0;
            ctrl_q  <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            pc4_q   <= '0;
            rs2_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
            we4_q   <= we4_d;
            rd4_q   <= rd4_d;
            ctrl_q  <= ctrl_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            pc4_q   <= pc4_d;
            rs2_q   <= rs2_d;
        end
    end

    assign valid4    = valid_q;
    assign we4       = we4_q;
    assign rd4       = rd4_q;
    assign ctrl4     = ctrl_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign pc4       = pc4_q;
    assign rs2_data4 = rs2_q;

`ifndef ISSUE_WB_BYPASS_EN
    // The WAW stall keeps a set and a clear off the same register.
    a_sb_set_clr: assert property (@(posedge clk) disable iff (nrst)
        !(sb_set && sb_clr && rd == rd6));
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage; hand-computed expectations.
// Covers both builds of ISSUE_WB_BYPASS_EN.
module tb_issue_stage;
    import issue_pkg::*;

    logic              clk = 1'b0;
    logic              nrst;
    logic              in_valid;
    logic              in_ready;
    logic [RA_W-1:0]   rs1, rs2, rd, rd6;
    logic              use_rs1, use_rs2, we, use_imm;
    logic [XLEN-1:0]   imm, pc, wb_data6;
    logic [CTRL_W-1:0] ctrl;
    logic              flush, we6;
    logic              valid4, we4;
    logic [XLEN-1:0]   op_a, op_b, pc4, rs2_data4;
    logic [RA_W-1:0]   rd4;
    logic [CTRL_W-1:0] ctrl4;

    int nvec = 0;
    int nerr = 0;

    issue_stage dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .use_rs1   (use_rs1),
        .use_rs2   (use_rs2),
        .rd        (rd),
        .we        (we),
        .use_imm   (use_imm),
        .imm       (imm),
        .pc        (pc),
        .ctrl      (ctrl),
        .flush     (flush),
        .we6       (we6),
        .rd6       (rd6),
        .wb_data6  (wb_data6),
        .valid4    (valid4),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd4       (rd4),
        .we4       (we4),
        .pc4       (pc4),
        .ctrl4     (ctrl4),
        .rs2_data4 (rs2_data4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pres(input logic [4:0] a1, input logic u1,
                        input logic [4:0] a2, input logic u2,
                        input logic [4:0] d, input logic w,
                        input logic ui, input logic [31:0] im,
                        input logic [31:0] p);
        in_valid = 1'b1;
        flush    = 1'b0;
        rs1      = a1;
        use_rs1  = u1;
        rs2      = a2;
        use_rs2  = u2;
        rd       = d;
        we       = w;
        use_imm  = ui;
        imm      = im;
        pc       = p;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] dt);
        we6      = 1'b1;
        rd6      = a;
        wb_data6 = dt;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, valid4, 0);
        chk({tag, "_we"}, we4, 0);
        chk({tag, "_rd"}, rd4, 0);
        chk({tag, "_opa"}, op_a, 0);
        chk({tag, "_opb"}, op_b, 0);
        chk({tag, "_pc"}, pc4, 0);
        chk({tag, "_ctrl"}, ctrl4, 0);
        chk({tag, "_rs2d"}, rs2_data4, 0);
    endtask

    initial begin
        nrst = 1'b1;
        in_valid = 0; flush = 0; we6 = 0; rd6 = 0; wb_data6 = 0;
        rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0; rd = 0; we = 0;
        use_imm = 0; imm = 0; pc = 0; ctrl = 0;
        step();
        step();
        chk_zero("rst");
        chk("rst_rdy", in_ready, 0);
        nrst = 1'b0;

        // addi x3, x0, 5
        pres(0, 1, 0, 0, 3, 1, 1, 5, 32'h100);
        ctrl = 40'h12_3456_789A;
        #1 chk("t1_rdy", in_ready, 1);
        step();
        chk("t1_valid", valid4, 1);
        chk("t1_opa", op_a, 0);
        chk("t1_opb", op_b, 5);
        chk("t1_rd", rd4, 3);
        chk("t1_we", we4, 1);
        chk("t1_pc", pc4, 32'h100);
        chk("t1_ctrl", ctrl4, 40'h12_3456_789A);

        // RAW on x3
        pres(3, 1, 0, 1, 5, 1, 0, 0, 32'h104);
        ctrl = 40'hAB;
        #1 chk("raw_rdy", in_ready, 0);
        step();
        chk("raw_b_valid", valid4, 0);
        chk("raw_b_we", we4, 0);
        chk("raw_b_rd", rd4, 0);
        chk("raw_b_ctrl", ctrl4, 0);
        step();
        chk("raw_b2_valid", valid4, 0);
        wb(3, 32'h2A);
        #1;
`ifdef ISSUE_WB_BYPASS_EN
        chk("raw_wb_rdy", in_ready, 1);
        step();
        we6 = 0;
`else
        chk("raw_wb_rdy", in_ready, 0);
        step();
        we6 = 0;
        chk("raw_wb_valid", valid4, 0);
        #1 chk("raw_post_rdy", in_ready, 1);
        step();
`endif
        chk("raw_valid", valid4, 1);
        chk("raw_opa", op_a, 32'h2A);
        chk("raw_opb", op_b, 0);
        chk("raw_rd", rd4, 5);
        chk("raw_ctrl", ctrl4, 40'hAB);
        in_valid = 0;
        wb(5, 32'h55);
        step();
        we6 = 0;
        chk("idle_valid", valid4, 0);

        // WAW on x7
        pres(0, 0, 0, 0, 7, 1, 1, 7, 32'h200);
        step();
        chk("waw1_valid", valid4, 1);
        pres(0, 0, 0, 0, 7, 1, 1, 8, 32'h204);
        #1 chk("waw_rdy", in_ready, 0);
        step();
        chk("waw_b_valid", valid4, 0);
        wb(7, 32'h77);
        #1;
`ifdef ISSUE_WB_BYPASS_EN
        chk("waw_wb_rdy", in_ready, 1);
        step();
        we6 = 0;
`else
        chk("waw_wb_rdy", in_ready, 0);
        step();
        we6 = 0;
        chk("waw_wb_valid", valid4, 0);
        #1 chk("waw_post_rdy", in_ready, 1);
        step();
`endif
        chk("waw_valid", valid4, 1);
        chk("waw_rd", rd4, 7);
        chk("waw_opb", op_b, 8);
        chk("waw_pc", pc4, 32'h204);
        chk("waw_reset_busy", in_ready, 0);
        in_valid = 0;
        wb(7, 32'h78);
        step();
        we6 = 0;

        // x0 destination and x0 writeback
        pres(0, 1, 3, 1, 0, 1, 0, 0, 32'h300);
        #1 chk("x0_rdy", in_ready, 1);
        step();
        chk("x0_valid", valid4, 1);
        chk("x0_we", we4, 1);
        chk("x0_rd", rd4, 0);
        chk("x0_opa", op_a, 0);
        chk("x0_opb", op_b, 32'h2A);
        chk("x0_rs2d", rs2_data4, 32'h2A);
        pres(0, 1, 0, 1, 0, 0, 0, 0, 32'h304);
        wb(0, 32'hFFFF);
        #1 chk("x0_busy_rdy", in_ready, 1);
        step();
        we6 = 0;
        chk("x0_wb_opa", op_a, 0);
        chk("x0_wb_opb", op_b, 0);
        pres(0, 1, 0, 1, 0, 0, 0, 0, 32'h308);
        step();
        chk("x0_rd_opa", op_a, 0);
        chk("x0_rd_pc", pc4, 32'h308);

        // Flush
        pres(3, 1, 0, 0, 10, 1, 0, 0, 32'h400);
        flush = 1;
        #1 chk("fl_rdy", in_ready, 1);
        step();
        flush = 0;
        chk("fl_valid", valid4, 0);
        chk("fl_we", we4, 0);
        chk("fl_rd", rd4, 0);
        pres(10, 1, 0, 0, 11, 1, 0, 0, 32'h404);
        #1 chk("fl_busy_rdy", in_ready, 1);
        step();
        chk("fl_next_valid", valid4, 1);
        chk("fl_next_opa", op_a, 0);
        chk("fl_next_rd", rd4, 11);
        chk("fl_next_pc", pc4, 32'h404);
        in_valid = 0;

        // Writeback to a non-busy reg, then reset mid-stall
        wb(4, 32'h44);
        step();
        we6 = 0;
        pres(4, 1, 0, 0, 4, 1, 0, 0, 32'h500);
        #1 chk("nb_rdy", in_ready, 1);
        step();
        chk("nb_valid", valid4, 1);
        chk("nb_opa", op_a, 32'h44);
        pres(4, 1, 0, 0, 12, 1, 0, 0, 32'h504);
        #1 chk("rs_stall_rdy", in_ready, 0);
        step();
        chk("rs_stall_valid", valid4, 0);
        nrst = 1'b1;
        #1 chk("rs_rdy", in_ready, 0);
        step();
        chk_zero("rs");
        nrst = 1'b0;
        pres(4, 1, 4, 1, 11, 1, 0, 0, 32'h508);
        #1 chk("rs_post_rdy", in_ready, 1);
        step();
        chk("rs_post_valid", valid4, 1);
        chk("rs_post_opa", op_a, 0);
        chk("rs_post_rs2d", rs2_data4, 0);
        chk("rs_post_rd", rd4, 11);
        in_valid = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
